// File: rtl/sra_arbiter.sv
// sra_arbiter: sequencer and two-way round-robin arbiter for the shared
// 32-bit arithmetic-shift-right unit.
//
// Accepts shift requests from two requesters over valid/ready handshakes.
// It drives the combinational shifter from registered state for one cycle.
// The shifter result is then held as a tagged response until the consumer
// accepts it.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request; arbitration and req_ready live here
//   SHIFT | operand/amount presented to the shifter, result captured at edge
//   HOLD  | response held valid until rsp_ready
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid[1:0]        per-requester valid
//   req_data0/1, amt0/1   operand and shift amount per requester
//   req_ready[1:0]        per-requester accept (one-hot or zero, IDLE only)
//   sh_inp, sh_sel        shared shifter operand and stage selects
//   sh_out                shifter result
//   rsp_valid/data/id     held response and the requester that issued it
//   rsp_ready             consumer accept
//   busy                  high whenever not IDLE
//   op_count              completed responses, wrapping
module sra_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [4:0]       req_amt0,
  input  logic [4:0]       req_amt1,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] sh_inp,
  output logic [4:0]       sh_sel,
  input  logic [WIDTH-1:0] sh_out,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic [WIDTH-1:0] r_op;
  logic [4:0]       r_amt;
  logic             r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_id;
  logic [CNT_W-1:0] r_cnt;

  logic             w_grant;
  logic             w_accept;
  logic [1:0]       w_ready;

  // With both requesters valid the pointer decides; otherwise whichever is
  // valid wins (bit 1 alone selects requester 1).
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = r_prio;
    end else begin
      w_grant = req_valid[1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 2'b00;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_ready[w_grant] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = SHIFT;
        end
      end
      SHIFT: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio      <= 1'b0;
      r_op        <= '0;
      r_amt       <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= w_grant ? req_data1 : req_data0;
        r_amt  <= w_grant ? req_amt1 : req_amt0;
        r_id   <= w_grant;
        r_prio <= ~w_grant;
      end
      if (r_state == SHIFT) begin
        r_rsp_data  <= sh_out;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      // rsp_valid is only ever high in HOLD, so this is the handshake edge.
      if (r_state == HOLD && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_cnt       <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Shifter inputs are forced to zero outside SHIFT so the shared unit sees
  // a quiet operand whenever this block does not own it.
  assign sh_inp    = (r_state == SHIFT) ? r_op  : '0;
  assign sh_sel    = (r_state == SHIFT) ? r_amt : '0;
  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_cnt;

endmodule
